match_sequencer: RTL and testbench

MATCH_SEQUENCER -- requirements
Module: match_sequencer

---
 rtl/match_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_match_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// Best-of-N match sequencer.
// Configures the game engine for each game, collects one move from each player
// per round, issues the move pair to the engine and tallies game results until
// a player has won a majority or all N games have been played.
//
// Handshake: a move transfers on a rising clk edge when pN_valid && pN_ready.
// pN_ready depends only on registered state, never on pN_valid.
module match_sequencer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_games,
    input  logic [1:0]       cfg_primo,
    input  logic [1:0]       cfg_secondo,
    input  logic             p1_valid,
    input  logic             p2_valid,
    input  logic [1:0]       p1_move,
    input  logic [1:0]       p2_move,
    output logic             p1_ready,
    output logic             p2_ready,
    output logic             g_inizia,
    output logic [1:0]       g_primo,
    output logic [1:0]       g_secondo,
    input  logic [1:0]       g_manche,
    input  logic [1:0]       g_partita,
    output logic [CNT_W-1:0] wins1,
    output logic [CNT_W-1:0] wins2,
    output logic [CNT_W-1:0] played,
    output logic             busy,
    output logic             match_done,
    output logic [1:0]       match_winner,
    output logic             err_move,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG     = 3'd1,
        S_COLLECT = 3'd2,
        S_ISSUE   = 3'd3,
        S_WAIT    = 3'd4,
        S_TALLY   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [1:0]       cfg1_q, cfg1_d;
    logic [1:0]       cfg2_q, cfg2_d;
    logic [1:0]       slot1_q, slot1_d;
    logic [1:0]       slot2_q, slot2_d;
    logic [1:0]       result_q, result_d;
    logic [CNT_W-1:0] wins1_q, wins1_d;
    logic [CNT_W-1:0] wins2_q, wins2_d;
    logic [CNT_W-1:0] played_q, played_d;
    logic [1:0]       winner_q, winner_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] eff_n;
    logic [CNT_W:0]   need_wins;

    // The per-round result is not needed: games advance on g_partita only.
    logic unused_manche;
    assign unused_manche = ^g_manche;

    // Effective match length is always odd. The maximum 2^CNT_W-1 is odd, so
    // every even request (including max-1) rounds up to at most the maximum.
    always_comb begin
        eff_n = num_games;
        if (num_games == '0) begin
            eff_n = CNT_W'(1);
        end else if (!num_games[0]) begin
            eff_n = num_games + CNT_W'(1);
        end
    end

    // Majority threshold (N+1)/2, one bit wider so N = max cannot overflow.
    assign need_wins = ({1'b0, n_q} + (CNT_W+1)'(1)) >> 1;

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cfg1_d     = cfg1_q;
        cfg2_d     = cfg2_q;
        slot1_d    = slot1_q;
        slot2_d    = slot2_q;
        result_d   = result_q;
        wins1_d    = wins1_q;
        wins2_d    = wins2_q;
        played_d   = played_q;
        winner_d   = winner_q;
        err_d      = 1'b0;
        g_inizia   = 1'b0;
        g_primo    = 2'b00;
        g_secondo  = 2'b00;
        p1_ready   = 1'b0;
        p2_ready   = 1'b0;
        match_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d      = eff_n;
                    cfg1_d   = cfg_primo;
                    cfg2_d   = cfg_secondo;
                    slot1_d  = 2'b00;
                    slot2_d  = 2'b00;
                    wins1_d  = '0;
                    wins2_d  = '0;
                    played_d = '0;
                    winner_d = 2'b00;
                    state_d  = S_CFG;
                end
            end
            S_CFG: begin
                g_inizia  = 1'b1;
                g_primo   = cfg1_q;
                g_secondo = cfg2_q;
                state_d   = S_COLLECT;
            end
            S_COLLECT: begin
                p1_ready = (slot1_q == 2'b00);
                p2_ready = (slot2_q == 2'b00);
                if (slot1_q != 2'b00 && slot2_q != 2'b00) begin
                    state_d = S_ISSUE;
                end
                // A 00 move is consumed but leaves the slot empty.
                if (p1_valid && p1_ready) begin
                    if (p1_move != 2'b00) slot1_d = p1_move;
                    else                  err_d   = 1'b1;
                end
                if (p2_valid && p2_ready) begin
                    if (p2_move != 2'b00) slot2_d = p2_move;
                    else                  err_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                g_primo   = slot1_q;
                g_secondo = slot2_q;
                slot1_d   = 2'b00;
                slot2_d   = 2'b00;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (g_partita != 2'b00) begin
                    result_d = g_partita;
                    state_d  = S_TALLY;
                end else begin
                    state_d  = S_COLLECT;
                end
            end
            S_TALLY: begin
                played_d = played_q + CNT_W'(1);
                if (result_q == 2'b01) wins1_d = wins1_q + CNT_W'(1);
                if (result_q == 2'b10) wins2_d = wins2_q + CNT_W'(1);
                if ({1'b0, wins1_d} >= need_wins || {1'b0, wins2_d} >= need_wins ||
                    played_d == n_q) begin
                    if (wins1_d > wins2_d)      winner_d = 2'b01;
                    else if (wins2_d > wins1_d) winner_d = 2'b10;
                    else                        winner_d = 2'b11;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CFG;
                end
            end
            S_DONE: begin
                match_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            cfg1_q   <= 2'b00;
            cfg2_q   <= 2'b00;
            slot1_q  <= 2'b00;
            slot2_q  <= 2'b00;
            result_q <= 2'b00;
            wins1_q  <= '0;
            wins2_q  <= '0;
            played_q <= '0;
            winner_q <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cfg1_q   <= cfg1_d;
            cfg2_q   <= cfg2_d;
            slot1_q  <= slot1_d;
            slot2_q  <= slot2_d;
            result_q <= result_d;
            wins1_q  <= wins1_d;
            wins2_q  <= wins2_d;
            played_q <= played_d;
            winner_q <= winner_d;
            err_q    <= err_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign wins1        = wins1_q;
    assign wins2        = wins2_q;
    assign played       = played_q;
    assign match_winner = winner_q;
    assign err_move     = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Testbench for match_sequencer: table of hand-computed matches, directed
// multi-cycle corner cases, and random matches checked against a match model.
`timescale 1ns/1ps
module tb_match_sequencer;
  localparam int CNT_W = 3;
  localparam int MAX_G = 7;

  logic clk = 1'b0;
  logic rst, start;
  logic [CNT_W-1:0] num_games;
  logic [1:0] cfg_primo, cfg_secondo;
  logic p1_valid, p2_valid;
  logic [1:0] p1_move, p2_move;
  logic p1_ready, p2_ready;
  logic g_inizia;
  logic [1:0] g_primo, g_secondo;
  logic [1:0] g_manche, g_partita;
  logic [CNT_W-1:0] wins1, wins2, played;
  logic busy, match_done;
  logic [1:0] match_winner;
  logic err_move;
  logic [2:0] dbg_state;

  match_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_games(num_games),
    .cfg_primo(cfg_primo), .cfg_secondo(cfg_secondo),
    .p1_valid(p1_valid), .p2_valid(p2_valid), .p1_move(p1_move), .p2_move(p2_move),
    .p1_ready(p1_ready), .p2_ready(p2_ready),
    .g_inizia(g_inizia), .g_primo(g_primo), .g_secondo(g_secondo),
    .g_manche(g_manche), .g_partita(g_partita),
    .wins1(wins1), .wins2(wins2), .played(played),
    .busy(busy), .match_done(match_done), .match_winner(match_winner),
    .err_move(err_move), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int inizia_seen, err_seen, exp_err;
  logic [1:0] exp_cfg1, exp_cfg2;
  logic [19:0] exp_q[$];       // {issue cycle[15:0], primo, secondo}
  logic [19:0] mon_e;
  logic [1:0] p1_q[$], p2_q[$];
  logic [1:0] game_res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: engine configuration pulses, issued move pairs, error pulses.
  always @(posedge clk) begin
    #2;
    if (g_inizia) begin
      inizia_seen++;
      check("cfg_primo", g_primo, exp_cfg1);
      check("cfg_secondo", g_secondo, exp_cfg2);
    end else if (g_primo != 2'b00 || g_secondo != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue", {cyc[15:0], g_primo, g_secondo}, mon_e);
      end
    end
    if (err_move) err_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_match(input logic [2:0] ng, input logic [1:0] c1, input logic [1:0] c2);
    num_games = ng;
    cfg_primo = c1;
    cfg_secondo = c2;
    exp_cfg1 = c1;
    exp_cfg2 = c2;
    inizia_seen = 0;
    err_seen = 0;
    exp_err = 0;
    exp_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One round: each player sends n_bad 00 moves then its real move, with
  // random gaps. post_ticks=3 holds g_partita until the engine sample is past.
  task automatic send_round(input logic [1:0] part, input logic [1:0] m1, input logic [1:0] m2,
                            input int bad1, input int bad2, input bit noise, input int post_ticks);
    int budget;
    int last_c;
    int t;
    logic x1, x2;
    g_partita = part;
    for (int i = 0; i < bad1; i++) p1_q.push_back(2'b00);
    for (int i = 0; i < bad2; i++) p2_q.push_back(2'b00);
    p1_q.push_back(m1);
    p2_q.push_back(m2);
    budget = 0;
    last_c = cyc;
    while ((p1_q.size() > 0 || p2_q.size() > 0) && budget < 300) begin
      p1_valid = (p1_q.size() > 0) && ($urandom_range(0, 3) != 0);
      p1_move  = p1_valid ? p1_q[0] : 2'($urandom_range(0, 3));
      p2_valid = (p2_q.size() > 0) && ($urandom_range(0, 3) != 0);
      p2_move  = p2_valid ? p2_q[0] : 2'($urandom_range(0, 3));
      if (noise) begin
        start       = ($urandom_range(0, 3) == 0);
        num_games   = 3'($urandom_range(0, 7));
        cfg_primo   = 2'($urandom_range(0, 3));
        cfg_secondo = 2'($urandom_range(0, 3));
      end
      if (p1_q.size() == 0) check("p1_ready_held", p1_ready, 0);
      if (p2_q.size() == 0) check("p2_ready_held", p2_ready, 0);
      x1 = p1_valid && p1_ready;
      x2 = p2_valid && p2_ready;
      if ((x1 && p1_move == 2'b00) || (x2 && p2_move == 2'b00)) exp_err++;
      if (x1 || x2) last_c = cyc;
      tick();
      if (x1) void'(p1_q.pop_front());
      if (x2) void'(p2_q.pop_front());
      budget++;
    end
    check("round_in_budget", budget < 300, 1);
    p1_q.delete();
    p2_q.delete();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    start = 1'b0;
    t = last_c + 2;
    exp_q.push_back({t[15:0], m1, m2});
    repeat (post_ticks) tick();
  endtask

  task automatic play_games(input int draws, input bit noise);
    int k;
    foreach (game_res_q[g]) begin
      k = (draws < 0) ? $urandom_range(0, 2) : draws;
      for (int r = 0; r <= k; r++) begin
        send_round((r < k) ? 2'b00 : game_res_q[g],
                   2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0,
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0,
                   noise, 3);
      end
    end
  endtask

  task automatic finish_match(input int e_played, input int e_w1, input int e_w2,
                              input logic [1:0] e_win, input int e_games);
    int b;
    b = 0;
    while (!match_done && b < 30) begin
      tick();
      b++;
    end
    check("done_pulse", match_done, 1);
    check("done_busy", busy, 1);
    check("played", played, e_played);
    check("wins1", wins1, e_w1);
    check("wins2", wins2, e_w2);
    check("winner", match_winner, e_win);
    tick();
    check("done_one_cycle", match_done, 0);
    check("idle_busy", busy, 0);
    check("winner_held", match_winner, e_win);
    check("played_held", played, e_played);
    check("inizia_count", inizia_seen, e_games);
    check("err_count", err_seen, exp_err);
    check("issue_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_p1_ready"}, p1_ready, 0);
    check({tag, "_p2_ready"}, p2_ready, 0);
    check({tag, "_g_inizia"}, g_inizia, 0);
    check({tag, "_g_primo"}, g_primo, 0);
    check({tag, "_g_secondo"}, g_secondo, 0);
    check({tag, "_wins1"}, wins1, 0);
    check({tag, "_wins2"}, wins2, 0);
    check({tag, "_played"}, played, 0);
    check({tag, "_winner"}, match_winner, 0);
    check({tag, "_match_done"}, match_done, 0);
    check({tag, "_err_move"}, err_move, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  ng;
    int          n_res;
    logic [13:0] res;      // game i result at res[2*i +: 2]
    logic [2:0]  e_played;
    logic [2:0]  e_w1;
    logic [2:0]  e_w2;
    logic [1:0]  e_win;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int b, n, w1, w2, p, ng;
    logic [1:0] r, win;

    tbl[0] = '{3'd3, 2, 14'b00_00_00_00_00_01_01, 3'd2, 3'd2, 3'd0, 2'b01};
    tbl[1] = '{3'd3, 3, 14'b00_00_00_00_10_11_11, 3'd3, 3'd0, 3'd1, 2'b10};
    tbl[2] = '{3'd0, 1, 14'b00_00_00_00_00_00_11, 3'd1, 3'd0, 3'd0, 2'b11};
    tbl[3] = '{3'd4, 5, 14'b00_00_11_10_01_10_01, 3'd5, 3'd2, 3'd2, 2'b11};
    tbl[4] = '{3'd6, 7, 14'b10_11_11_11_11_11_11, 3'd7, 3'd0, 3'd1, 2'b10};
    tbl[5] = '{3'd7, 4, 14'b00_00_00_10_10_10_10, 3'd4, 3'd0, 3'd4, 2'b10};
    tbl[6] = '{3'd2, 3, 14'b00_00_00_00_10_11_01, 3'd3, 3'd1, 3'd1, 2'b11};
    tbl[7] = '{3'd5, 3, 14'b00_00_00_00_01_01_01, 3'd3, 3'd3, 3'd0, 2'b01};
    tbl[8] = '{3'd1, 1, 14'b00_00_00_00_00_00_10, 3'd1, 3'd0, 3'd1, 2'b10};

    rst = 1'b1; start = 1'b0; num_games = '0; cfg_primo = '0; cfg_secondo = '0;
    p1_valid = 1'b0; p2_valid = 1'b0; p1_move = '0; p2_move = '0;
    g_manche = 2'b01; g_partita = 2'b00;
    inizia_seen = 0; err_seen = 0; exp_err = 0; exp_cfg1 = '0; exp_cfg2 = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("idle_not_busy", busy, 0);

    // Table-driven matches.
    for (int i = 0; i < 9; i++) begin
      game_res_q.delete();
      for (int g = 0; g < tbl[i].n_res; g++) game_res_q.push_back(tbl[i].res[2*g +: 2]);
      start_match(tbl[i].ng, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      play_games(-1, 1'b1);
      finish_match(tbl[i].e_played, tbl[i].e_w1, tbl[i].e_w2, tbl[i].e_win, tbl[i].n_res);
    end

    // Bad move then real move on p1; p2 arrives two cycles later.
    start_match(3'd0, 2'b11, 2'b01);
    g_partita = 2'b01;
    b = 0;
    while (!p1_ready && b < 20) begin tick(); b++; end
    check("p1_ready_collect", p1_ready, 1);
    p1_valid = 1'b1; p1_move = 2'b00;
    tick();
    check("err_pulse", err_move, 1);
    check("p1_ready_after_00", p1_ready, 1);
    p1_move = 2'b10;
    tick();
    p1_valid = 1'b0;
    check("err_single", err_move, 0);
    check("p1_ready_full", p1_ready, 0);
    tick();
    check("p1_ready_waiting", p1_ready, 0);
    check("p2_ready_waiting", p2_ready, 1);
    p2_valid = 1'b1; p2_move = 2'b01;
    b = cyc + 2;
    exp_q.push_back({b[15:0], 2'b10, 2'b01});
    exp_err = 1;
    tick();
    p2_valid = 1'b0;
    repeat (3) tick();
    finish_match(1, 1, 0, 2'b01, 1);

    // Three drawn rounds inside a single game.
    game_res_q.delete();
    game_res_q.push_back(2'b01);
    start_match(3'd0, 2'b10, 2'b10);
    play_games(3, 1'b0);
    finish_match(1, 1, 0, 2'b01, 1);

    // Reset while waiting on the engine in game 2, then a clean match.
    start_match(3'd3, 2'b01, 2'b10);
    send_round(2'b01, 2'b01, 2'b10, 0, 0, 1'b0, 3);
    send_round(2'b10, 2'b11, 2'b11, 0, 0, 1'b0, 2);
    check("pre_reset_played", played, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    exp_q.delete();
    tick();
    check("after_reset_idle", busy, 0);
    game_res_q.delete();
    game_res_q.push_back(2'b01);
    game_res_q.push_back(2'b01);
    start_match(3'd3, 2'b11, 2'b00);
    play_games(-1, 1'b1);
    finish_match(2, 2, 0, 2'b01, 2);

    // Random matches against a model built from the match rules.
    for (int m = 0; m < 30; m++) begin
      ng = $urandom_range(0, MAX_G);
      if (ng == 0) n = 1;
      else if (ng % 2 == 1) n = ng;
      else n = (ng + 1 > MAX_G) ? MAX_G : ng + 1;
      w1 = 0; w2 = 0; p = 0;
      game_res_q.delete();
      do begin
        r = 2'($urandom_range(1, 3));
        game_res_q.push_back(r);
        p++;
        if (r == 2'b01) w1++;
        else if (r == 2'b10) w2++;
      end while (!(2 * w1 >= n + 1 || 2 * w2 >= n + 1 || p == n));
      win = (w1 > w2) ? 2'b01 : (w2 > w1) ? 2'b10 : 2'b11;
      start_match(3'(ng), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      play_games(-1, 1'b1);
      finish_match(p, w1, w2, win, p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
